uart_16550_rx: RTL and testbench
================================

# uart_16550_rx

Serial receive front end for the `uart_16550` core. It synchronises the `rxd` pin and detects start bits using 16x oversampling from the divisor-latch baud tick. It deserialises 5–8 data bits with optional parity and checks parity, framing and break. Each completed character, with its error flags, is handed to the RX FIFO write port over a valid/ready handshake.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the `rxd` synchroniser (≥2).
- `OVERSAMPLE`, default 16: baud ticks per bit; the mid-bit sample is taken at count `OVERSAMPLE/2-1`.
- `clk` in 1: core clock; single clock domain.
- `rst` in 1: synchronous, active-low reset.
- `baud_tick` in 1: one-`clk` pulse at 16x baud, from the divisor counter.
- `rxd` in 1: asynchronous serial input; idles high.
- `wls` in 2: word length select; 0..3 selects 5..8 data bits.
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sp` in 1: stick parity.
- `rx_data` out 8: received character, LSB-first assembled; bits above the word length are 0.
- `rx_pe` out 1: parity error for `rx_data`.
- `rx_fe` out 1: framing error for `rx_data`.
- `rx_bi` out 1: break indication for `rx_data`.
- `rx_valid` out 1: character and flags held valid.
- `rx_ready` in 1: FIFO accepts the character.
- `rx_overrun` out 1: one-`clk` pulse when a character is dropped.
- `rx_busy` out 1: high in any state other than IDLE.

## Operation
- The synchroniser resets to all 1s. All sampling uses the synchronised `rxd_s`. State and counters advance only on cycles where `baud_tick` is high.
- States:
  - IDLE: on a tick with `rxd_s`=0, go to START with `cnt`=0.
  - START: `cnt` increments per tick. At `cnt`=7, re-sample. If `rxd_s`=1, it is a false start: return to IDLE with no output. If 0, go to DATA with `cnt`=0 and `bitn`=0.
  - DATA: at `cnt`=15, shift `rxd_s` into `shreg` at bit position `bitn` and clear `cnt`. After the bit with index `wls+4`, go to PARITY if `pen`, else to STOP.
  - PARITY: at `cnt`=15, capture the parity bit and go to STOP.
  - STOP: at `cnt`=15, sample the first stop bit only; the second stop bit is never checked. Then complete the character and go to IDLE, or to BRKWAIT if break was detected.
  - BRKWAIT: remain until a tick with `rxd_s`=1, then go to IDLE.
- Parity check:
  - Expected parity bit = XOR(data bits) XOR `~eps`.
  - When `sp`=1, expected parity bit = `~eps`.
  - `rx_pe` = `pen` AND (received ≠ expected).
- `rx_fe`: the stop sample is 0.
- Break: all data bits, the parity bit (if enabled) and the stop bit are 0. In that case `rx_bi`=1, `rx_fe`=1, `rx_pe`=0 and `rx_data`=0x00.
- Completion:
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle, load `rx_data` and the flags and set `rx_valid`=1.
  - Otherwise the new character is discarded, the held character is unchanged, and `rx_overrun` pulses once.
- `rx_valid` clears on a cycle with `rx_ready`=1 unless a completion occurs in that same cycle.
- `wls`, `pen`, `eps` and `sp` are sampled live. The LCR must not be changed while `rx_busy`=1; results are undefined if it is.

## Timing
- Reset state: IDLE. `rx_data`=0, `rx_pe`=`rx_fe`=`rx_bi`=0, `rx_valid`=0, `rx_overrun`=0, `rx_busy`=0.
- Reset mid-character aborts the character with no output.
- Input latency: `SYNC_STAGES` clks from `rxd` to `rxd_s`.
- Output latency:
  - `rx_valid`, `rx_data` and the flags are registered. They update in the `clk` after the tick at which the stop bit is sampled.
  - `rx_overrun` is asserted in that same cycle.
- Handshake: the transfer occurs on a cycle with `rx_valid`=1 and `rx_ready`=1. Outputs remain stable while `rx_valid`=1 and `rx_ready`=0.
- `rx_busy` rises the `clk` after the start-detect tick. It falls the `clk` after the stop sample, or after the BRKWAIT exit.
- A new start bit is detected on the first tick after returning to IDLE, so back-to-back characters with one stop bit are supported.
- `cnt` is 4 bits and wraps at 15. `bitn` is 3 bits.

## Test plan
- 8N1 (`wls`=3, `pen`=0), frame 0xA5, `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0xA5 and all flags 0. The `rx_valid` pulse arrives 1 clk after the stop-sample tick.
- 7E1 (`wls`=2, `pen`=1, `eps`=1), send 0x41 with the parity bit 1 (wrong) → `rx_data`=0x41, `rx_pe`=1. Repeat with the parity bit 0 → `rx_pe`=0. With `sp`=1, `eps`=1, parity bit 0 → `rx_pe`=0.
- 5N1, send 0x1F with the stop bit 0, followed by a correct frame 0x0A → first character `rx_data`=0x1F with `rx_fe`=1; second character 0x0A with `rx_fe`=0.
- 8N1, hold `rxd` low for 3 character times, then release → exactly one character with `rx_data`=0x00 and `rx_bi`=`rx_fe`=1. `rx_busy` stays high until `rxd` returns high; no further characters are produced.
- `rxd` low glitch for 4 baud ticks while idle → no `rx_valid`, and the block is back in IDLE by tick 8.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11, with `rx_overrun` pulsing once at the end of 0x22. Then assert `rx_ready` for 1 clk → `rx_valid` deasserts.

Source files
------------

// File: rtl/uart_16550_rx.sv
// uart_16550 receive front end: rxd synchroniser, 16x oversampled start detect,
// 5-8 bit deserialiser with parity/framing/break checks and a valid/ready output.
module uart_16550_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [2:0]             bitn;
  logic [2:0]             last_bit;
  logic [7:0]             shreg;
  logic                   par_q;
  logic                   exp_par;
  logic                   brk;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Bits above the word length stay 0 in shreg, so a full-width XOR is the data parity.
  always_comb begin
    cnt_nxt  = (cnt == LAST) ? '0 : cnt + 1'b1;
    last_bit = {1'b1, wls};
    exp_par  = sp ? ~eps : (^shreg) ^ ~eps;
    brk      = (shreg == '0) && !(pen && par_q) && !rxd_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      rx_pe      <= 1'b0;
      rx_fe      <= 1'b0;
      rx_bi      <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_ready) rx_valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state   <= START;
              cnt     <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt == MID) begin
              if (rxd_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
                cnt   <= '0;
                bitn  <= '0;
                shreg <= '0;
                par_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            cnt <= cnt_nxt;
            if (cnt == LAST) begin
              shreg[bitn] <= rxd_s;
              bitn        <= bitn + 3'd1;
              if (bitn == last_bit) state <= pen ? PARITY : STOP;
            end
          end
          PARITY: begin
            cnt <= cnt_nxt;
            if (cnt == LAST) begin
              par_q <= rxd_s;
              state <= STOP;
            end
          end
          STOP: begin
            cnt <= cnt_nxt;
            if (cnt == LAST) begin
              state   <= brk ? BRKWAIT : IDLE;
              rx_busy <= brk;
              if (!rx_valid || rx_ready) begin
                rx_valid <= 1'b1;
                rx_data  <= brk ? '0 : shreg;
                rx_pe    <= !brk && pen && (par_q != exp_par);
                rx_fe    <= !rxd_s;
                rx_bi    <= brk;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end
          BRKWAIT: begin
            if (rxd_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_16550_rx.sv
// Directed and randomised frames for uart_16550_rx, checked against a
// character-level model of the UART receive rules.
module tb_uart_16550_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] wls = 2'd3;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_pe, rx_fe, rx_bi, rx_valid, rx_overrun, rx_busy;

  int n_checks = 0;
  int n_pass = 0;
  int div = 0;
  int tick_cnt = 0;
  int clk_cnt = 0;
  int last_tick_clk = 0;
  int rise_tick = 0;
  int rise_lag = 0;
  int rise_cnt = 0;
  int ovr_cnt = 0;
  logic valid_d = 1'b0;
  logic [10:0] got[$];
  logic [10:0] exp_val;
  int exp_tick;

  uart_16550_rx #(.SYNC_STAGES(2), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd),
    .wls(wls), .pen(pen), .eps(eps), .sp(sp),
    .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Baud tick every third clk, changed on the falling edge.
  always @(negedge clk) begin
    div = (div == 2) ? 0 : div + 1;
    baud_tick = (div == 0);
  end

  always @(posedge clk) begin
    clk_cnt++;
    if (baud_tick) begin
      tick_cnt++;
      last_tick_clk = clk_cnt;
    end
  end

  always @(negedge clk) begin
    if (rx_valid && !valid_d) begin
      rise_tick = tick_cnt;
      rise_lag  = clk_cnt - last_tick_clk;
      rise_cnt++;
    end
    valid_d = rx_valid;
    if (rx_valid && rx_ready) got.push_back({rx_bi, rx_fe, rx_pe, rx_data});
    if (rx_overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected {bi, fe, pe, data} for one character.
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w,
                                        input logic p_en, input logic e, input logic s,
                                        input logic pb, input logic sb);
    int n;
    logic [7:0] dm;
    logic ep;
    n  = int'(w) + 5;
    dm = d & 8'((1 << n) - 1);
    ep = s ? ~e : ((^dm) ^ ~e);
    if (dm == 8'h00 && !(p_en && pb) && !sb) return {3'b110, 8'h00};
    return {1'b0, ~sb, p_en && (pb != ep), dm};
  endfunction

  task automatic wait_tick();
    do @(posedge clk); while (!baud_tick);
    #1;
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p_en,
                            input logic e, input logic s, input logic pb, input logic sb);
    int n;
    n = int'(w) + 5;
    wls = w; pen = p_en; eps = e; sp = s;
    exp_val = model(d, w, p_en, e, s, pb, sb);
    wait_tick();
    rxd = 1'b0;
    // start seen one tick later, mid-start 8 ticks after that, then 16 ticks per bit
    exp_tick = tick_cnt + 9 + 16 * (n + 1 + int'(p_en));
    wait_ticks(16);
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
    if (p_en) begin
      rxd = pb;
      wait_ticks(16);
    end
    rxd = sb;
    wait_ticks(16);
    rxd = 1'b1;
  endtask

  task automatic expect_char(input string tag);
    logic [10:0] v;
    chk({tag, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      v = got.pop_front();
      chk(tag, v, exp_val);
    end
    chk({tag, "_tick"}, rise_tick, exp_tick);
    chk({tag, "_lag"}, rise_lag, 0);
  endtask

  initial begin
    logic [10:0] first_exp;
    int base, ovr0, ts;

    repeat (6) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {rx_pe, rx_fe, rx_bi}, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 1'b1;
    wait_ticks(20);

    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(8);
    expect_char("8n1_a5");
    chk("8n1_idle_busy", rx_busy, 0);

    send_frame(8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_ticks(8);
    expect_char("7e1_bad_par");
    send_frame(8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(8);
    expect_char("7e1_good_par");
    send_frame(8'h41, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_ticks(8);
    expect_char("7e1_stick");

    send_frame(8'h1F, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(20);
    expect_char("5n1_fe");
    send_frame(8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(8);
    expect_char("5n1_ok");

    // back-to-back 8N1 with a single stop bit
    send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_first", got.size(), 1);
    if (got.size() > 0) chk("b2b_first_val", got.pop_front(), exp_val);
    send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(8);
    expect_char("b2b_second");

    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic [1:0] w;
      logic p_en, e, s, pb, sb;
      d    = 8'($urandom);
      w    = 2'($urandom_range(0, 3));
      p_en = 1'($urandom);
      e    = 1'($urandom);
      s    = 1'($urandom);
      pb   = 1'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      if (i == 5) begin
        d = 8'h00; pb = 1'b0; sb = 1'b0;
      end
      send_frame(d, w, p_en, e, s, pb, sb);
      wait_ticks(24);
      expect_char($sformatf("rand%0d", i));
      chk($sformatf("rand%0d_busy", i), rx_busy, 0);
    end

    // sustained break
    wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    exp_val = model(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    base = rise_cnt;
    wait_tick();
    rxd = 1'b0;
    ts = tick_cnt;
    wait_ticks(480);
    chk("brk_busy_low", rx_busy, 1);
    chk("brk_count", got.size(), 1);
    if (got.size() > 0) chk("brk_val", got.pop_front(), exp_val);
    chk("brk_tick", rise_tick, ts + 9 + 16 * 9);
    rxd = 1'b1;
    wait_ticks(3);
    chk("brk_busy_release", rx_busy, 0);
    wait_ticks(40);
    chk("brk_one_char", rise_cnt - base, 1);
    chk("brk_no_more", got.size(), 0);

    // 4-tick glitch while idle
    base = rise_cnt;
    wait_tick();
    rxd = 1'b0;
    wait_ticks(4);
    chk("glitch_busy", rx_busy, 1);
    rxd = 1'b1;
    wait_ticks(6);
    chk("glitch_idle", rx_busy, 0);
    wait_ticks(30);
    chk("glitch_no_char", rise_cnt - base, 0);

    // overrun with the FIFO stalled
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    first_exp = exp_val;
    wait_ticks(20);
    chk("ovr_valid1", rx_valid, 1);
    chk("ovr_data1", rx_data, 8'h11);
    send_frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(20);
    chk("ovr_data_held", rx_data, 8'h11);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("ovr_valid_clear", rx_valid, 0);
    chk("ovr_taken_count", got.size(), 1);
    if (got.size() > 0) chk("ovr_taken_val", got.pop_front(), first_exp);
    rx_ready = 1'b1;
    wait_ticks(10);
    chk("ovr_no_late", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
